sync_filter_bank: RTL and testbench
===================================

Name: sync_filter_bank

Overview:
- Multi-channel synchroniser with per-channel glitch filter and edge detection.
- Each of WIDTH asynchronous inputs passes through a STAGES-deep flop chain, then a consecutive-sample filter.
- Each channel produces a registered filtered level plus one-cycle rise and fall pulses.
- Sits at the accelerator boundary for async control inputs (buttons, external strobes, foreign-domain flags) feeding FSMs that need clean, single-cycle events.

Parameters:
- WIDTH, 4: number of independent channels.
- STAGES, 2: synchroniser flop depth per channel. Values below 2 are an elaboration error.
- FILTER_LEN, 4: consecutive cycles the synchronised value must differ from filt_out before filt_out updates. Values below 1 are an elaboration error.
- RST_VAL, '0 (WIDTH bits): per-channel reset value of every sync flop and of filt_out.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- async_in  input  WIDTH  asynchronous inputs, one per channel.
- sync_out  output  WIDTH  raw synchronised value (last chain stage), unfiltered.
- filt_out  output  WIDTH  filtered, registered level.
- rise_pulse  output  WIDTH  one-cycle high when filt_out[i] goes 0->1.
- fall_pulse  output  WIDTH  one-cycle high when filt_out[i] goes 1->0.
- any_edge  output  1  OR of all rise_pulse and fall_pulse bits, same cycle.

Behaviour:
- Reset (rst high at a clk edge):
  - all chain flops and filt_out take RST_VAL[i];
  - filter counters clear to 0;
  - rise_pulse, fall_pulse and any_edge are 0.
  - Reset mid-count discards the count.
  - No pulse is generated at or after reset release unless a real filtered transition occurs.
- Sync chain:
  - stage0 <= async_in; stage k <= stage k-1; sync_out = stage STAGES-1.
  - A change sampled at edge N appears on sync_out after edge N+STAGES-1.
- Filter, one counter per channel, width $clog2(FILTER_LEN), minimum 1 bit:
  - If sync_out[i] == filt_out[i]: counter <= 0.
  - Else if counter == FILTER_LEN-1: filt_out[i] <= sync_out[i], counter <= 0.
  - Else: counter <= counter+1.
- Latency: an input held stable from before edge 1 reaches filt_out after edge STAGES+FILTER_LEN. With defaults that is edge 6.
- Glitch rejection:
  - Any sync_out[i] deviation shorter than FILTER_LEN cycles leaves filt_out[i] unchanged and produces no pulse.
  - A return to the filt_out value mid-count resets the counter to 0; there is no partial credit.
- FILTER_LEN=1: filt_out follows sync_out with exactly one cycle of delay.
- Edges:
  - rise_pulse[i] and fall_pulse[i] are registered and assert in the same cycle filt_out[i] first shows its new value, for exactly one cycle.
  - They are never both high for one channel.
- Channels are fully independent. Simultaneous transitions on several channels each give their own pulse; any_edge is high for that single cycle.
- Continuous toggling with a period shorter than 2*FILTER_LEN cycles never changes filt_out.

Optional Feature:
- Macro: SYNC_FILTER_STICKY_EN.
- Defined:
  - adds input evt_clr [WIDTH] and output evt_flags [WIDTH];
  - evt_flags[i] sets on rise_pulse[i] or fall_pulse[i] and holds until evt_clr[i] is sampled high;
  - set and clear in the same cycle: set wins;
  - rst clears evt_flags to 0.
- Undefined: neither port exists and no sticky logic is synthesised. All other behaviour is identical.

Test Plan:
- Defaults, rst high 2 cycles then low, async_in=4'b0000 -> sync_out=filt_out=0, no pulses for 20 cycles.
- Raise async_in[0] before edge 1 and hold -> sync_out[0]=1 after edge 2, filt_out[0]=1 and rise_pulse[0]=1 after edge 6, rise_pulse[0]=0 after edge 7, any_edge mirrors rise_pulse[0].
- filt_out[1]=0; pulse async_in[1] high for 3 cycles, then low -> sync_out[1] shows a 3-cycle pulse, filt_out[1] stays 0, no pulses.
- Channels 2 and 3 filtered high; drop both on the same cycle -> fall_pulse=4'b1100 for exactly one cycle, filt_out=4'b0011.
- Assert rst during cycle 2 of a count on channel 0 -> counter and filt_out return to RST_VAL; with input held, the transition re-completes STAGES+FILTER_LEN edges after release.
- SYNC_FILTER_STICKY_EN defined: rise on ch0, evt_clr=4'b0001 asserted in the pulse cycle -> evt_flags[0]=1 (set wins); next clear -> evt_flags[0]=0.

Source files
------------

// File: rtl/sync_filter_bank.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_bank
// Description : Multi-channel synchroniser with a per-channel glitch filter
//               and registered rise/fall pulses. Define SYNC_FILTER_STICKY_EN
//               to add sticky per-channel event flags with clear inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_bank #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
`ifdef SYNC_FILTER_STICKY_EN
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] evt_flags,
`endif
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_edge
);

    localparam int                 c_CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_LEN - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_filter_bank: STAGES must be at least 2");
        end
        if (FILTER_LEN < 1) begin : g_bad_filter_len
            $error("sync_filter_bank: FILTER_LEN must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= RST_VAL;
            end
        end else begin
            r_sync[0] <= async_in;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign sync_out = r_sync[STAGES-1];

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_filt;
            logic               r_rise;
            logic               r_fall;

            // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_filt <= RST_VAL[i];
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (sync_out[i] == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_filt <= sync_out[i];
                        r_rise <= sync_out[i];
                        r_fall <= ~sync_out[i];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign filt_out[i]   = r_filt;
            assign rise_pulse[i] = r_rise;
            assign fall_pulse[i] = r_fall;
        end
    endgenerate

    assign any_edge = |(rise_pulse | fall_pulse);

`ifdef SYNC_FILTER_STICKY_EN
    logic [WIDTH-1:0] r_evt;

    // Set term is ORed last so a same-cycle set overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt <= '0;
        end else begin
            r_evt <= (r_evt & ~evt_clr) | rise_pulse | fall_pulse;
        end
    end

    assign evt_flags = r_evt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_filter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_filter_bank
// Description : Self-checking bench for sync_filter_bank with a behavioural
//               reference model, directed scenarios and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_filter_bank;

    localparam int W  = 4;
    localparam int ST = 2;
    localparam int FL = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] async_in = '0;
    logic [W-1:0] sync_out, filt_out, rise_pulse, fall_pulse;
    logic         any_edge;
`ifdef SYNC_FILTER_STICKY_EN
    logic [W-1:0] evt_clr = '0;
    logic [W-1:0] evt_flags;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    sync_filter_bank #(
        .WIDTH     (W),
        .STAGES    (ST),
        .FILTER_LEN(FL),
        .RST_VAL   ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
`ifdef SYNC_FILTER_STICKY_EN
        .evt_clr   (evt_clr),
        .evt_flags (evt_flags),
`endif
        .sync_out  (sync_out),
        .filt_out  (filt_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_edge  (any_edge)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sample delay line, then per channel a count of
    // consecutive disagreeing samples; FL in a row commits the new level.
    logic [W-1:0] m_line [ST];
    logic [W-1:0] m_filt, m_rise, m_fall, m_s;
    int           m_run [W];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ST; k++) m_line[k] = '0;
            m_filt = '0;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < W; c++) m_run[c] = 0;
        end else begin
            m_s    = m_line[ST-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < W; c++) begin
                if (m_s[c] != m_filt[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] >= FL) begin
                        m_filt[c] = m_s[c];
                        if (m_s[c]) m_rise[c] = 1'b1;
                        else        m_fall[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            for (int k = ST-1; k > 0; k--) m_line[k] = m_line[k-1];
            m_line[0] = async_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sync_out",   32'(sync_out),   32'(m_line[ST-1]));
            chk("filt_out",   32'(filt_out),   32'(m_filt));
            chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
            chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
            chk("any_edge",   32'(any_edge),   32'(|(m_rise | m_fall)));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        // Reset and idle
        rst = 1'b1;
        async_in = '0;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        chk("reset filt_out", 32'(filt_out), 32'h0);
        chk("reset any_edge", 32'(any_edge), 32'h0);
        rst = 1'b0;
        tick(20);
        chk("idle filt_out", 32'(filt_out), 32'h0);

        // Rise on channel 0 with edge numbering from reset release
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        async_in = 4'b0001;
        tick(1);
        chk("ch0 sync edge1", 32'(sync_out[0]), 32'h0);
        tick(1);
        chk("ch0 sync edge2", 32'(sync_out[0]), 32'h1);
        tick(3);
        chk("ch0 filt edge5", 32'(filt_out[0]), 32'h0);
        tick(1);
        chk("ch0 filt edge6", 32'(filt_out[0]), 32'h1);
        chk("ch0 rise edge6", 32'(rise_pulse), 32'h1);
        chk("ch0 any edge6",  32'(any_edge), 32'h1);
`ifdef SYNC_FILTER_STICKY_EN
        evt_clr = 4'b0001;
`endif
        tick(1);
        chk("ch0 rise edge7", 32'(rise_pulse), 32'h0);
        chk("ch0 any edge7",  32'(any_edge), 32'h0);
`ifdef SYNC_FILTER_STICKY_EN
        chk("sticky set wins", 32'(evt_flags[0]), 32'h1);
        tick(1);
        chk("sticky cleared", 32'(evt_flags[0]), 32'h0);
        evt_clr = 4'b0000;
`endif

        // Three-cycle glitch on channel 1 is rejected
        async_in[1] = 1'b1;
        tick(3);
        async_in[1] = 1'b0;
        tick(10);
        chk("ch1 glitch filt", 32'(filt_out[1]), 32'h0);

        // All high, then channels 2 and 3 drop together
        async_in = 4'b1111;
        tick(8);
        chk("all high filt", 32'(filt_out), 32'hf);
        async_in = 4'b0011;
        tick(5);
        chk("ch23 fall early", 32'(fall_pulse), 32'h0);
        tick(1);
        chk("ch23 fall pulse", 32'(fall_pulse), 32'hc);
        chk("ch23 filt",       32'(filt_out), 32'h3);
        tick(1);
        chk("ch23 fall end",   32'(fall_pulse), 32'h0);

        // Reset mid-count on channel 0
        async_in = 4'b0000;
        tick(8);
        async_in[0] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("midcount rst filt", 32'(filt_out), 32'h0);
        rst = 1'b0;
        tick(5);
        chk("rerun filt edge5", 32'(filt_out[0]), 32'h0);
        tick(1);
        chk("rerun filt edge6", 32'(filt_out[0]), 32'h1);
        chk("rerun rise edge6", 32'(rise_pulse), 32'h1);

        // Toggle channel 2 with period 6, shorter than 2*FL
        for (int n = 0; n < 14; n++) begin
            async_in[2] = ~async_in[2];
            tick(3);
        end
        async_in[2] = 1'b0;
        tick(2);
        chk("toggle filt ch2", 32'(filt_out[2]), 32'h0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(0, 7) == 0) async_in[c] = ~async_in[c];
            end
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(10);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
